// File: rtl/disp_sched_pkg.sv
// rtl/disp_sched_pkg.sv - shared constants, frame record and arbitration helper for the display scheduler
package disp_sched_pkg;

  localparam int SRC_TIME = 0;
  localparam int SRC_SET  = 1;
  localparam int SRC_ALM  = 2;
  localparam int SRC_N    = 3;

  localparam int DIGIT_W  = 4;
  localparam int DIGIT_N  = 6;
  localparam int NUM_W    = DIGIT_W * DIGIT_N;

  localparam int DEF_FRAME_CYC    = 50000;
  localparam int DEF_BLINK_FRAMES = 250;
  localparam int DEF_MIN_HOLD     = 2;

  typedef logic [SRC_N-1:0] gnt_t;

  typedef struct packed {
    logic [NUM_W-1:0]   num;
    logic [DIGIT_N-1:0] dp;
    logic [DIGIT_N-1:0] tw;
  } frame_t;

  // Fixed priority alarm > setting > time; time needs no request since it is the default owner.
  function automatic gnt_t pick_candidate(input logic req_alm, input logic req_set);
    gnt_t g;
    g = '0;
    if (req_alm)      g[SRC_ALM]  = 1'b1;
    else if (req_set) g[SRC_SET]  = 1'b1;
    else              g[SRC_TIME] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/disp_sched_if.sv
// rtl/disp_sched_if.sv - source-side request/data bundle and display-side frame outputs
interface disp_sched_if;
  import disp_sched_pkg::*;

  logic [SRC_N-1:0]   req;
  logic [NUM_W-1:0]   src0_num;
  logic [DIGIT_N-1:0] src0_dp;
  logic [DIGIT_N-1:0] src0_tw;
  logic [NUM_W-1:0]   src1_num;
  logic [DIGIT_N-1:0] src1_dp;
  logic [DIGIT_N-1:0] src1_tw;
  logic [NUM_W-1:0]   src2_num;
  logic [DIGIT_N-1:0] src2_dp;
  logic [DIGIT_N-1:0] src2_tw;

  logic [SRC_N-1:0]   gnt;
  logic               valid_sd;
  logic [DIGIT_W-1:0] num6;
  logic [DIGIT_W-1:0] num5;
  logic [DIGIT_W-1:0] num4;
  logic [DIGIT_W-1:0] num3;
  logic [DIGIT_W-1:0] num2;
  logic [DIGIT_W-1:0] num1;
  logic [DIGIT_N-1:0] dp;
  logic [DIGIT_N-1:0] twinkle;

  modport master (
    output req, src0_num, src0_dp, src0_tw, src1_num, src1_dp, src1_tw,
           src2_num, src2_dp, src2_tw,
    input  gnt, valid_sd, num6, num5, num4, num3, num2, num1, dp, twinkle
  );

  modport slave (
    input  req, src0_num, src0_dp, src0_tw, src1_num, src1_dp, src1_tw,
           src2_num, src2_dp, src2_tw,
    output gnt, valid_sd, num6, num5, num4, num3, num2, num1, dp, twinkle
  );

endinterface

// File: rtl/disp_sched_frame_tick_gen.sv
// rtl/disp_sched_frame_tick_gen.sv - free-running frame counter, tick high on its last cycle
module frame_tick_gen
  import disp_sched_pkg::*;
#(
  parameter int FRAME_CYC = DEF_FRAME_CYC
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = $clog2(FRAME_CYC);
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYC - 1);

  logic [CW-1:0] fcnt_q;
  logic [CW-1:0] fcnt_d;

  assign tick_o = (fcnt_q == LAST);

  always_comb begin
    fcnt_d = tick_o ? '0 : fcnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) fcnt_q <= '0;
    else       fcnt_q <= fcnt_d;
  end

endmodule

// File: rtl/disp_sched.sv
// rtl/disp_sched.sv - per-frame source arbitration with minimum hold, frozen frame capture and blink phase
module disp_sched
  import disp_sched_pkg::*;
#(
  parameter int FRAME_CYC    = DEF_FRAME_CYC,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  parameter int MIN_HOLD     = DEF_MIN_HOLD
) (
  input  logic        sysclk,
  input  logic        rst,
  disp_sched_if.slave bus
);

  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(MIN_HOLD - 1);

  logic               tick;
  gnt_t               cand;
  frame_t             sel;

  gnt_t               gnt_q,     gnt_d;
  logic [HW-1:0]      hold_q,    hold_d;
  logic [BW-1:0]      bcnt_q,    bcnt_d;
  logic               phase_q,   phase_d;
  logic               valid_q,   valid_d;
  logic [NUM_W-1:0]   num_q,     num_d;
  logic [DIGIT_N-1:0] dp_q,      dp_d;
  logic [DIGIT_N-1:0] twinkle_q, twinkle_d;

  frame_tick_gen #(
    .FRAME_CYC (FRAME_CYC)
  ) u_tick (
    .clk_i  (sysclk),
    .rst_i  (rst),
    .tick_o (tick)
  );

  always_comb begin
    gnt_d     = gnt_q;
    hold_d    = hold_q;
    bcnt_d    = bcnt_q;
    phase_d   = phase_q;
    valid_d   = 1'b0;
    num_d     = num_q;
    dp_d      = dp_q;
    twinkle_d = twinkle_q;
    cand      = pick_candidate(bus.req[SRC_ALM], bus.req[SRC_SET]);
    sel       = '{num: bus.src0_num, dp: bus.src0_dp, tw: bus.src0_tw};

    if (tick) begin
      valid_d = 1'b1;
      if (bcnt_q == BLINK_LAST) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d  = bcnt_q + 1'b1;
      end

      // A fresh owner restarts the blink field visible so its first frame is never blanked.
      if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else if (cand != gnt_q) begin
        gnt_d   = cand;
        hold_d  = HOLD_LOAD;
        bcnt_d  = '0;
        phase_d = 1'b0;
      end

      if (gnt_d[SRC_ALM])
        sel = '{num: bus.src2_num, dp: bus.src2_dp, tw: bus.src2_tw};
      else if (gnt_d[SRC_SET])
        sel = '{num: bus.src1_num, dp: bus.src1_dp, tw: bus.src1_tw};

      num_d     = sel.num;
      dp_d      = sel.dp;
      twinkle_d = sel.tw & {DIGIT_N{phase_d}};
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      gnt_q     <= gnt_t'(1) << SRC_TIME;
      hold_q    <= '0;
      bcnt_q    <= '0;
      phase_q   <= 1'b0;
      valid_q   <= 1'b0;
      num_q     <= '0;
      dp_q      <= '0;
      twinkle_q <= '0;
    end else begin
      gnt_q     <= gnt_d;
      hold_q    <= hold_d;
      bcnt_q    <= bcnt_d;
      phase_q   <= phase_d;
      valid_q   <= valid_d;
      num_q     <= num_d;
      dp_q      <= dp_d;
      twinkle_q <= twinkle_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.valid_sd = valid_q;
  assign bus.num6     = num_q[23:20];
  assign bus.num5     = num_q[19:16];
  assign bus.num4     = num_q[15:12];
  assign bus.num3     = num_q[11:8];
  assign bus.num2     = num_q[7:4];
  assign bus.num1     = num_q[3:0];
  assign bus.dp       = dp_q;
  assign bus.twinkle  = twinkle_q;

endmodule

// File: tb/tb_disp_sched.sv
// tb/tb_disp_sched.sv - table-driven frame checks with a scoreboard for the display scheduler
module tb_disp_sched;
  import disp_sched_pkg::*;

  localparam int FC = 8;

  typedef struct {
    logic [2:0]  gnt;
    logic [23:0] num;
    logic [5:0]  dp;
    logic [5:0]  tw;
  } out_t;

  typedef struct {
    logic [2:0]  req;
    logic [23:0] s1num;
    out_t        exp;
  } vec_t;

  logic sysclk = 1'b0;
  logic rst;

  disp_sched_if ifc();

  disp_sched #(
    .FRAME_CYC    (FC),
    .BLINK_FRAMES (2),
    .MIN_HOLD     (2)
  ) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (ifc.slave)
  );

  always #5 sysclk = ~sysclk;

  vec_t vecs[12];
  out_t sb_q[$];
  out_t last;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   since   = 0;

  function automatic out_t mk(input logic [2:0] g, input logic [23:0] n,
                              input logic [5:0] d, input logic [5:0] t);
    out_t o;
    o.gnt = g; o.num = n; o.dp = d; o.tw = t;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.gnt = ifc.gnt;
    o.num = {ifc.num6, ifc.num5, ifc.num4, ifc.num3, ifc.num2, ifc.num1};
    o.dp  = ifc.dp;
    o.tw  = ifc.twinkle;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // One clock; between strobes the frame outputs must stay frozen.
  task automatic cycle();
    out_t o;
    @(negedge sysclk);
    since++;
    if (!ifc.valid_sd) begin
      o = sample();
      check("frozen_between_strobes", {o.gnt, o.num, o.dp, o.tw},
            {last.gnt, last.num, last.dp, last.tw});
    end
  endtask

  task automatic wait_strobe(input string tag, input int exp_period);
    bit   found;
    out_t e;
    out_t o;
    found = 1'b0;
    for (int i = 0; i < 4 * FC; i++) begin
      cycle();
      if (ifc.valid_sd) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no valid_sd within %0d cycles", tag, 4 * FC);
      return;
    end
    check({tag, "_period"}, 64'(since), 64'(exp_period));
    o = sample();
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_scoreboard: strobe with no expected frame", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_gnt"},     64'(o.gnt), 64'(e.gnt));
      check({tag, "_num"},     64'(o.num), 64'(e.num));
      check({tag, "_dp"},      64'(o.dp),  64'(e.dp));
      check({tag, "_twinkle"}, 64'(o.tw),  64'(e.tw));
    end
    last  = o;
    since = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t o;
    ifc.req      = 3'b000;
    ifc.src0_num = 24'h123456; ifc.src0_dp = 6'h01; ifc.src0_tw = 6'h03;
    ifc.src1_num = 24'h654321; ifc.src1_dp = 6'h02; ifc.src1_tw = 6'h3C;
    ifc.src2_num = 24'h999000; ifc.src2_dp = 6'h20; ifc.src2_tw = 6'h30;

    //           req     src1_num     gnt     num          dp     twinkle
    vecs[0]  = '{3'b000, 24'h654321, mk(3'b001, 24'h123456, 6'h01, 6'h00)};
    vecs[1]  = '{3'b000, 24'h654321, mk(3'b001, 24'h123456, 6'h01, 6'h03)};
    vecs[2]  = '{3'b000, 24'h654321, mk(3'b001, 24'h123456, 6'h01, 6'h03)};
    vecs[3]  = '{3'b110, 24'h654321, mk(3'b100, 24'h999000, 6'h20, 6'h00)};
    vecs[4]  = '{3'b010, 24'h654321, mk(3'b100, 24'h999000, 6'h20, 6'h00)};
    vecs[5]  = '{3'b010, 24'h654321, mk(3'b010, 24'h654321, 6'h02, 6'h00)};
    vecs[6]  = '{3'b010, 24'h654321, mk(3'b010, 24'h654321, 6'h02, 6'h00)};
    vecs[7]  = '{3'b010, 24'h777777, mk(3'b010, 24'h777777, 6'h02, 6'h3C)};
    vecs[8]  = '{3'b000, 24'h777777, mk(3'b001, 24'h123456, 6'h01, 6'h00)};
    vecs[9]  = '{3'b000, 24'h777777, mk(3'b001, 24'h123456, 6'h01, 6'h00)};
    vecs[10] = '{3'b000, 24'h777777, mk(3'b001, 24'h123456, 6'h01, 6'h03)};
    vecs[11] = '{3'b100, 24'h777777, mk(3'b100, 24'h999000, 6'h20, 6'h00)};

    rst = 1'b1;
    repeat (2) @(negedge sysclk);
    o = sample();
    check("reset_gnt",      64'(o.gnt), 64'(3'b001));
    check("reset_valid_sd", 64'(ifc.valid_sd), 64'(0));
    check("reset_num",      64'(o.num), 64'(0));
    check("reset_dp",       64'(o.dp),  64'(0));
    check("reset_twinkle",  64'(o.tw),  64'(0));
    rst   = 1'b0;
    since = 0;
    last  = o;

    // Inputs change three cycles into each frame; they must only show at the next strobe.
    for (int i = 0; i < 12; i++) begin
      repeat (3) cycle();
      ifc.req      = vecs[i].req;
      ifc.src1_num = vecs[i].s1num;
      sb_q.push_back(vecs[i].exp);
      wait_strobe($sformatf("vec%0d", i), FC);
    end

    // Reset pulse in the middle of a frame owned by the alarm source.
    repeat (3) cycle();
    check("pre_reset_gnt", 64'(ifc.gnt), 64'(3'b100));
    rst     = 1'b1;
    ifc.req = 3'b000;
    @(negedge sysclk);
    o = sample();
    check("midrst_gnt",      64'(o.gnt), 64'(3'b001));
    check("midrst_valid_sd", 64'(ifc.valid_sd), 64'(0));
    check("midrst_num",      64'(o.num), 64'(0));
    check("midrst_dp",       64'(o.dp),  64'(0));
    check("midrst_twinkle",  64'(o.tw),  64'(0));
    rst   = 1'b0;
    since = 0;
    last  = o;
    sb_q.push_back(mk(3'b001, 24'h123456, 6'h01, 6'h00));
    wait_strobe("post_rst", FC);

    // A short alarm pulse between ticks is never seen by the arbiter.
    repeat (2) cycle();
    ifc.req = 3'b100;
    repeat (3) cycle();
    ifc.req = 3'b000;
    sb_q.push_back(mk(3'b001, 24'h123456, 6'h01, 6'h03));
    wait_strobe("pulse", FC);
    sb_q.push_back(mk(3'b001, 24'h123456, 6'h01, 6'h03));
    wait_strobe("pulse_after", FC);

    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/disp_sched.md
Name: disp_sched

Overview:
- Frame scheduler and arbiter in front of the 6-digit serial display interface (the 74HC595 shifter block).
- Three display sources share the one display: time (src0), setting (src1) and alarm/notice (src2).
- Each frame, selects the owning source, latches its digits, decimal points and blink mask, and fires one valid_sd strobe so the shifter sends a clean, unmixed frame.
- Generates the blink phase that gates the twinkle mask.

Parameters:
FRAME_CYC, 50000, sysclk cycles per display frame (1 ms at 50 MHz); must be >= 2
BLINK_FRAMES, 250, frames per blink half-period (0.25 s)
MIN_HOLD, 2, minimum frames a grant is held after any grant change

Ports:
sysclk  in  1  system clock
rst  in  1  synchronous, active-high reset
req  in  3  level requests; bit i = source i wants display; req[0] ignored (src0 is default owner)
src0_num  in  24  src0 digits, [23:20]=num6 … [3:0]=num1, BCD
src0_dp  in  6  src0 decimal-point enables
src0_tw  in  6  src0 blink mask (1 = digit blinks)
src1_num, src1_dp, src1_tw  in  24/6/6  as src0
src2_num, src2_dp, src2_tw  in  24/6/6  as src0
gnt  out  3  one-hot current owner
valid_sd  out  1  one-cycle frame strobe to display interface
num6..num1  out  4 each  latched digits
dp  out  6  latched decimal points
twinkle  out  6  latched blink mask AND blink phase (1 = blank digit now)

Behaviour:
- Reset (rst=1 at a sysclk edge), any time, including mid-frame:
  - gnt=3'b001; valid_sd=0; num6..num1=0; dp=0; twinkle=0.
  - Frame, blink and hold counters = 0; blink phase = 0 (visible); hold counter expired.
- Frame timer: fcnt counts 0..FRAME_CYC-1 and wraps. tick=1 combinationally when fcnt==FRAME_CYC-1. First tick occurs FRAME_CYC cycles after rst deasserts.
- Arbitration is evaluated only on tick, never mid-frame.
  - Candidate = src2 if req[2], else src1 if req[1], else src0.
  - If hold counter > 0: keep current gnt and decrement the counter.
  - Else if candidate != current: switch gnt, load hold counter with MIN_HOLD-1, reset blink counter and set phase=0 so a new field is immediately visible.
  - Else keep gnt.
  - Request changes between ticks are not seen. Requesters hold req at least one full frame plus the hold time. A req that drops before the tick is lost; no queuing.
- Capture, on the same tick edge as the gnt update:
  - num6..num1, dp and tw are latched from the newly granted source.
  - valid_sd=1 for exactly the next cycle.
  - Outputs stay stable for the whole frame, so the shifter samples frozen data.
  - Latency: tick cycle N -> new gnt, data and valid_sd all visible in cycle N+1. valid_sd period = FRAME_CYC cycles exactly.
- Blink:
  - bcnt counts ticks 0..BLINK_FRAMES-1; on wrap, phase toggles.
  - twinkle = latched_tw & {6{phase}}, registered and updated on tick only (same edge as capture).
- Data is passed unchanged; BCD range is not checked.
- Simultaneous requests: fixed priority src2 > src1 > src0; no fairness beyond MIN_HOLD.
- MIN_HOLD=1: the grant may change on every tick. MIN_HOLD=0 is illegal.
- Counter widths are $clog2 of their limit. No counter saturates or overflows; all wrap at their terminal value.

Decomposition:
- Shared parameter include (the codebase's para file) gets:
  - source index constants SRC_TIME=0, SRC_SET=1, SRC_ALM=2
  - digit width 4, digit count 6
  - default FRAME_CYC and BLINK_FRAMES
- One sub-module, frame_tick_gen: parameterised FRAME_CYC counter, output tick, sync active-high rst.
- Arbitration, hold, capture and blink logic stay in disp_sched.

Test Plan:
(All scenarios use FRAME_CYC=8, BLINK_FRAMES=2, MIN_HOLD=2.)
- Reset release, req=0, src0_num=24'h123456 -> first valid_sd 8 cycles after release, then one pulse every 8 cycles; num6..num1=1,2,3,4,5,6; gnt=001.
- req=3'b110 held -> at next tick gnt=100 and src2 data appears; drop req[2] before the following tick -> gnt stays 100 for that tick (hold), then becomes 010 at the tick after.
- src1_num changes mid-frame -> outputs unchanged until the next valid_sd; no output change between strobes.
- src0_tw=6'b000011, stable -> twinkle alternates 000000 / 000011, toggling every 2 frames; it goes to 000000 at the tick where gnt changes.
- Assert rst for 1 cycle mid-frame while gnt=100 -> next cycle: all outputs 0, gnt=001, and the next valid_sd comes 8 cycles after rst drops.
- req[2] pulses high for 3 cycles between ticks -> gnt never leaves 001.
